// File: rtl/reg_transfer_sequencer_pkg.sv
// Shared definitions for the register-transfer sequencer: opcode map, class ranges, state codes, strobe bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package reg_transfer_sequencer_pkg;

  // Opcode field position inside the instruction word
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int OPC_W  = OPC_HI - OPC_LO + 1;

  // Opcode encodings and class range bounds (inclusive)
  localparam logic [OPC_W-1:0] OPC_LD       = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_LDI      = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_ST       = 5'b00010;
  localparam logic [OPC_W-1:0] OPC_RTYPE_LO = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_RTYPE_HI = 5'b01011;
  localparam logic [OPC_W-1:0] OPC_ITYPE_LO = 5'b01100;
  localparam logic [OPC_W-1:0] OPC_ITYPE_HI = 5'b01110;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_T_B      = 4'd1,
    S_T_C      = 4'd2,
    S_T_IMM    = 4'd3,
    S_T_MAR    = 4'd4,
    S_T_ST     = 4'd5,
    S_MEM_WAIT = 4'd6,
    S_T_LDWB   = 4'd7,
    S_T_WB     = 4'd8,
    S_DONE     = 4'd9,
    S_ERR      = 4'd10
  } state_t;

  // One-hot opcode class
  typedef struct packed {
    logic ld;
    logic ldi;
    logic st;
    logic rtype;
    logic itype;
    logic illegal;
  } op_class_t;

  // Every phase strobe driven by the sequencer
  typedef struct packed {
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic ba_out;
    logic y_in;
    logic z_in;
    logic z_out;
    logic c_out;
    logic mar_in;
    logic mdr_in;
    logic mdr_out;
    logic read;
    logic write;
    logic done;
    logic illegal;
  } strobe_t;

endpackage

// File: rtl/reg_seq_classify.sv
// Combinational opcode-to-class decoder (one-hot: LD, LDI, ST, RTYPE, ITYPE, ILLEGAL).
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
// Ports: opcode (5-bit opcode field) in, cls (one-hot class) out.
module reg_seq_classify
  import reg_transfer_sequencer_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output op_class_t        cls
);

  always_comb begin
    cls       = '0;
    cls.ld    = (opcode == OPC_LD);
    cls.ldi   = (opcode == OPC_LDI);
    cls.st    = (opcode == OPC_ST);
    cls.rtype = (opcode >= OPC_RTYPE_LO) && (opcode <= OPC_RTYPE_HI);
    cls.itype = (opcode >= OPC_ITYPE_LO) && (opcode <= OPC_ITYPE_HI);
    cls.illegal = !(cls.ld || cls.ldi || cls.st || cls.rtype || cls.itype);
  end

endmodule

// File: rtl/reg_transfer_sequencer.sv
// Multi-cycle register-transfer sequencer: latches an instruction, classifies it, steps its phase strobes.
// Latency: first phase in the cycle after start is accepted; done after 4 (ALU), 6+k (LD/ST) or 1 (illegal) cycles.
// Backpressure: start ignored while busy (not queued); MEM_WAIT stalls until mem_ready.
// Ports: clock, clear (async active-low), start, ir[31:0], mem_ready in; register selects, register-file
// enables, BA_out, datapath/memory strobes, busy, done, illegal out.
// Build option: BA_OUT_EN makes LD/LDI/ST read their base through BA_out (R0 reads zero).
module reg_transfer_sequencer
  import reg_transfer_sequencer_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        r_in_enable,
  output logic        r_out_enable,
  output logic        BA_out,
  output logic        Y_in,
  output logic        Z_in,
  output logic        Z_out,
  output logic        C_out,
  output logic        MAR_in,
  output logic        MDR_in,
  output logic        MDR_out,
  output logic        read,
  output logic        write,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  state_t          state_q;
  state_t          state_n;
  logic [31:0]     ir_q;
  strobe_t         strb_q;
  op_class_t       cls;
  logic [OPC_W-1:0] opcode_sel;
  logic            unused_ir_bits;

  // In IDLE classify the incoming word so the first phase's strobes can be
  // registered on the accepting edge; afterwards classify the latched copy.
  assign opcode_sel = (state_q == S_IDLE) ? ir[OPC_HI:OPC_LO] : ir_q[OPC_HI:OPC_LO];

  reg_seq_classify u_classify (
    .opcode (opcode_sel),
    .cls    (cls)
  );

  // Operand fields are consumed downstream from the IR itself, not here.
  assign unused_ir_bits = ^ir_q[OPC_LO-1:0];

  function automatic strobe_t phase_strobes(input state_t s, input op_class_t c);
    strobe_t o;
    o = '0;
    case (s)
      S_T_B: begin
        o.grb  = 1'b1;
        o.y_in = 1'b1;
`ifdef BA_OUT_EN
        if (c.ld || c.ldi || c.st) o.ba_out = 1'b1;
        else                       o.r_out  = 1'b1;
`else
        o.r_out = 1'b1;
`endif
      end
      S_T_C:      begin o.grc = 1'b1; o.r_out = 1'b1; o.z_in = 1'b1; end
      S_T_IMM:    begin o.c_out = 1'b1; o.z_in = 1'b1; end
      S_T_MAR:    begin o.z_out = 1'b1; o.mar_in = 1'b1; end
      S_T_ST:     begin o.gra = 1'b1; o.r_out = 1'b1; o.mdr_in = 1'b1; end
      S_MEM_WAIT: begin o.read = c.ld; o.write = c.st; end
      S_T_LDWB:   begin o.mdr_out = 1'b1; o.gra = 1'b1; o.r_in = 1'b1; end
      S_T_WB:     begin o.z_out = 1'b1; o.gra = 1'b1; o.r_in = 1'b1; end
      S_DONE:     o.done = 1'b1;
      S_ERR:      begin o.illegal = 1'b1; o.done = 1'b1; end
      default:    ;
    endcase
    return o;
  endfunction

  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:     if (start) state_n = cls.illegal ? S_ERR : S_T_B;
      S_T_B:      state_n = cls.rtype ? S_T_C : S_T_IMM;
      S_T_C:      state_n = S_T_WB;
      S_T_IMM:    state_n = (cls.ld || cls.st) ? S_T_MAR : S_T_WB;
      S_T_MAR:    state_n = cls.st ? S_T_ST : S_MEM_WAIT;
      S_T_ST:     state_n = S_MEM_WAIT;
      S_MEM_WAIT: if (mem_ready) state_n = cls.ld ? S_T_LDWB : S_DONE;
      S_T_LDWB:   state_n = S_DONE;
      S_T_WB:     state_n = S_DONE;
      S_DONE:     state_n = S_IDLE;
      S_ERR:      state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state, so each one is a clean Moore
  // output that holds for the whole cycle of its phase.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_n;
      strb_q  <= phase_strobes(state_n, cls);
      if (state_q == S_IDLE && start) ir_q <= ir;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign Gra          = strb_q.gra;
  assign Grb          = strb_q.grb;
  assign Grc          = strb_q.grc;
  assign r_in_enable  = strb_q.r_in;
  assign r_out_enable = strb_q.r_out;
  assign BA_out       = strb_q.ba_out;
  assign Y_in         = strb_q.y_in;
  assign Z_in         = strb_q.z_in;
  assign Z_out        = strb_q.z_out;
  assign C_out        = strb_q.c_out;
  assign MAR_in       = strb_q.mar_in;
  assign MDR_in       = strb_q.mdr_in;
  assign MDR_out      = strb_q.mdr_out;
  assign read         = strb_q.read;
  assign write        = strb_q.write;
  assign done         = strb_q.done;
  assign illegal      = strb_q.illegal;

endmodule
